// File: rtl/extnet_pkg.sv
// Shared definitions for the ExtNet window sequencer.
//   state_t     - window sequencer states (IDLE, ARM, FEED, FLUSH)
//   log2c()     - ceiling log2 used to size the scan and result counters
//   pixel_bitw()- RGB pixel bus width for a given channel width
package extnet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FEED  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int CH_PER_PIXEL  = 3;
  localparam int UINT_BITW_DEF = 8;
  localparam int PIX_BITW_DEF  = UINT_BITW_DEF * CH_PER_PIXEL;

  // Ceiling log2, never below 1 so a degenerate dimension still gets a bit.
  function automatic int log2c(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int pixel_bitw(input int uint_bitw);
    return uint_bitw * CH_PER_PIXEL;
  endfunction

endpackage

// File: rtl/extnet_window_ctrl_if.sv
// Pixel path between the patch buffer, the window sequencer and the network.
//   src_valid/src_data/src_ready : upstream pixel handshake
//   net_pixel/net_vcnt/net_hcnt  : registered pixel and scan coordinate to extnet
// master = sequencer side, slave = patch buffer / network side.
interface extnet_window_ctrl_if #(
  parameter int PIX_BITW = 24,
  parameter int V_BITW   = 5,
  parameter int H_BITW   = 5
);
  logic                src_valid;
  logic [PIX_BITW-1:0] src_data;
  logic                src_ready;
  logic [PIX_BITW-1:0] net_pixel;
  logic [V_BITW-1:0]   net_vcnt;
  logic [H_BITW-1:0]   net_hcnt;

  modport master (
    input  src_valid, src_data,
    output src_ready, net_pixel, net_vcnt, net_hcnt
  );

  modport slave (
    output src_valid, src_data,
    input  src_ready, net_pixel, net_vcnt, net_hcnt
  );
endinterface

// File: rtl/extnet_scan_counter.sv
// Free-running W_HEIGHT x W_WIDTH raster scan.
//   clock, n_rst : clock, asynchronous active-low reset
//   vcnt, hcnt   : current row / column
//   wrap_next    : scan sits on the last coordinate, so the next one is (0,0)
module extnet_scan_counter
  import extnet_pkg::*;
#(
  parameter int W_HEIGHT = 32,
  parameter int W_WIDTH  = 32,
  parameter int V_BITW   = log2c(W_HEIGHT),
  parameter int H_BITW   = log2c(W_WIDTH)
) (
  input  logic              clock,
  input  logic              n_rst,
  output logic [V_BITW-1:0] vcnt,
  output logic [H_BITW-1:0] hcnt,
  output logic              wrap_next
);

  localparam logic [V_BITW-1:0] V_LAST = V_BITW'(W_HEIGHT - 1);
  localparam logic [H_BITW-1:0] H_LAST = H_BITW'(W_WIDTH - 1);

  logic h_last;
  assign h_last    = (hcnt == H_LAST);
  assign wrap_next = h_last && (vcnt == V_LAST);

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      vcnt <= '0;
      hcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/extnet_window_ctrl.sv
// ExtNet window sequencer: gates one W_HEIGHT x W_WIDTH window of upstream
// pixels into the network on request and flags the network output cycles
// that carry that window's features.
//   clock, n_rst : clock, asynchronous active-low reset
//   start        : one-cycle request, honoured only in IDLE
//   busy         : sequencer not in IDLE
//   res_valid    : network output belongs to the window
//   done         : pulses with the last res_valid
//   underrun     : sticky, src_valid was low during FEED
//   err_count    : underrun cycle count (saturating)
//   bus          : pixel handshake and registered coordinates (master)
// Build option: define EXTNET_CTRL_ERRCNT_EN to implement err_count;
// otherwise it is tied to zero.
module extnet_window_ctrl
  import extnet_pkg::*;
#(
  parameter int W_HEIGHT  = 32,
  parameter int W_WIDTH   = 32,
  parameter int UINT_BITW = 8,
  parameter int LATENCY   = 200,
  parameter int V_BITW    = log2c(W_HEIGHT),
  parameter int H_BITW    = log2c(W_WIDTH)
) (
  input  logic        clock,
  input  logic        n_rst,
  input  logic        start,
  output logic        busy,
  output logic        res_valid,
  output logic        done,
  output logic        underrun,
  output logic [15:0] err_count,
  extnet_window_ctrl_if.master bus
);

  localparam int PIX_BITW = pixel_bitw(UINT_BITW);
  localparam int N_PIX    = W_HEIGHT * W_WIDTH;
  // Result counter runs from FEED entry (0) to one past the final result.
  localparam int RC_BITW  = log2c(LATENCY + N_PIX + 2);
  localparam logic [RC_BITW-1:0] RES_FIRST = RC_BITW'(LATENCY + 1);
  localparam logic [RC_BITW-1:0] RES_LAST  = RC_BITW'(LATENCY + N_PIX);

  state_t              state, state_next;
  logic [V_BITW-1:0]   vcnt;
  logic [H_BITW-1:0]   hcnt;
  logic                wrap_next;
  logic [RC_BITW-1:0]  res_cnt;
  logic                in_window;
  logic                start_acc;
  logic                starve;
  logic [PIX_BITW-1:0] pix_next;

  extnet_scan_counter #(
    .W_HEIGHT (W_HEIGHT),
    .W_WIDTH  (W_WIDTH),
    .V_BITW   (V_BITW),
    .H_BITW   (H_BITW)
  ) u_scan (
    .clock     (clock),
    .n_rst     (n_rst),
    .vcnt      (vcnt),
    .hcnt      (hcnt),
    .wrap_next (wrap_next)
  );

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = ARM;
      ARM:     if (wrap_next) state_next = FEED;   // next coordinate is (0,0)
      FEED:    if (wrap_next) state_next = FLUSH;  // last window coordinate
      FLUSH:   if (done)      state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    bus.src_ready = (state == FEED);
    in_window     = (state == FEED) || (state == FLUSH);
    res_valid     = in_window && (res_cnt >= RES_FIRST) && (res_cnt <= RES_LAST);
    done          = (state == FLUSH) && (res_cnt == RES_LAST);
    start_acc     = (state == IDLE) && start;
    starve        = bus.src_ready && !bus.src_valid;
    pix_next      = (bus.src_ready && bus.src_valid) ? bus.src_data : '0;
  end

  // res_cnt reads 0 on the first FEED cycle; the pixel sampled then reaches
  // net_pixel one cycle later, so results span counts LATENCY+1..LATENCY+N.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      bus.net_pixel <= '0;
      bus.net_vcnt  <= '0;
      bus.net_hcnt  <= '0;
      res_cnt       <= '0;
      underrun      <= 1'b0;
    end else begin
      bus.net_pixel <= pix_next;
      bus.net_vcnt  <= vcnt;
      bus.net_hcnt  <= hcnt;
      res_cnt       <= in_window ? res_cnt + 1'b1 : '0;
      if (start_acc)   underrun <= 1'b0;
      else if (starve) underrun <= 1'b1;
    end
  end

`ifdef EXTNET_CTRL_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst)                                err_cnt_q <= '0;
    else if (start_acc)                        err_cnt_q <= '0;
    else if (starve && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_extnet_window_ctrl.sv
// Self-checking bench: two sequencers (LATENCY 5 and 40, 4x4 window) share
// stimulus; an arithmetic schedule model predicts every output each cycle.
module tb_extnet_window_ctrl;

  localparam int WH = 4;
  localparam int WW = 4;
  localparam int N  = WH * WW;
  localparam int UB = 8;
  localparam int PW = UB * 3;
  localparam int VB = extnet_pkg::log2c(WH);
  localparam int HB = extnet_pkg::log2c(WW);
`ifdef EXTNET_CTRL_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clock, n_rst, start;
  logic busy_o [2], rv_o [2], done_o [2], ur_o [2], rdy_o [2];
  logic [15:0]   err_o [2];
  logic [PW-1:0] pix_o [2];
  logic [VB-1:0] v_o [2];
  logic [HB-1:0] h_o [2];

  extnet_window_ctrl_if #(.PIX_BITW(PW), .V_BITW(VB), .H_BITW(HB)) if5 ();
  extnet_window_ctrl_if #(.PIX_BITW(PW), .V_BITW(VB), .H_BITW(HB)) if40 ();

  extnet_window_ctrl #(.W_HEIGHT(WH), .W_WIDTH(WW), .UINT_BITW(UB), .LATENCY(5)) dut5 (
    .clock(clock), .n_rst(n_rst), .start(start), .busy(busy_o[0]), .res_valid(rv_o[0]),
    .done(done_o[0]), .underrun(ur_o[0]), .err_count(err_o[0]), .bus(if5));

  extnet_window_ctrl #(.W_HEIGHT(WH), .W_WIDTH(WW), .UINT_BITW(UB), .LATENCY(40)) dut40 (
    .clock(clock), .n_rst(n_rst), .start(start), .busy(busy_o[1]), .res_valid(rv_o[1]),
    .done(done_o[1]), .underrun(ur_o[1]), .err_count(err_o[1]), .bus(if40));

  assign rdy_o[0] = if5.src_ready;   assign rdy_o[1] = if40.src_ready;
  assign pix_o[0] = if5.net_pixel;   assign pix_o[1] = if40.net_pixel;
  assign v_o[0]   = if5.net_vcnt;    assign v_o[1]   = if40.net_vcnt;
  assign h_o[0]   = if5.net_hcnt;    assign h_o[1]   = if40.net_hcnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: window i was accepted so that ARM begins at cycle m_arm, FEED
  // occupies [m_f0, m_f0+N) and results occupy (m_f0+L, m_f0+L+N].
  int            cyc;
  bit            m_act [2];
  int            m_arm [2], m_f0 [2], m_err [2], dn_cnt [2];
  bit            m_ur  [2];
  logic [PW-1:0] m_pix [2];
  int            n_tests, n_fail;

  typedef struct {
    int gap;
    int bad_a;
    int bad_b;
    bit exp_ur;
    int exp_err;
  } vec_t;
  vec_t vecs [4];

  function automatic int lat_of(input int i);
    return (i == 0) ? 5 : 40;
  endfunction

  function automatic bit feeding(input int i, input int c);
    return m_act[i] && (c >= m_f0[i]) && (c < m_f0[i] + N);
  endfunction

  function automatic bit m_busy(input int i, input int c);
    return m_act[i] && (c >= m_arm[i]) && (c <= m_f0[i] + lat_of(i) + N);
  endfunction

  function automatic bit m_res(input int i, input int c);
    return m_act[i] && (c > m_f0[i] + lat_of(i)) && (c <= m_f0[i] + lat_of(i) + N);
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (LATENCY=%0d) cycle %0d: got %0h, expected %0h",
               name, lat_of(inst), cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_ur[i] = 0; m_err[i] = 0; m_pix[i] = '0;
      m_arm[i] = 0; m_f0[i] = 0;
    end
  endtask

  task automatic check_all();
    int idx;
    idx = (cyc == 0) ? 0 : (cyc - 1) % N;
    for (int i = 0; i < 2; i++) begin
      check("busy",      i, busy_o[i], m_busy(i, cyc));
      check("src_ready", i, rdy_o[i],  feeding(i, cyc));
      check("res_valid", i, rv_o[i],   m_res(i, cyc));
      check("done",      i, done_o[i], m_act[i] && (cyc == m_f0[i] + lat_of(i) + N));
      check("net_pixel", i, pix_o[i],  m_pix[i]);
      check("net_vcnt",  i, v_o[i],    idx / WW);
      check("net_hcnt",  i, h_o[i],    idx % WW);
      check("underrun",  i, ur_o[i],   m_ur[i]);
      check("err_count", i, err_o[i],  ERR_EN ? m_err[i] : 0);
      if (i == 1) check("feed_result_overlap", i, rv_o[i] && rdy_o[i], 0);
    end
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      check({name, "_busy"}, i, busy_o[i], 0);
      check({name, "_src_ready"}, i, rdy_o[i], 0);
      check({name, "_res_valid"}, i, rv_o[i], 0);
      check({name, "_done"}, i, done_o[i], 0);
      check({name, "_underrun"}, i, ur_o[i], 0);
      check({name, "_err_count"}, i, err_o[i], 0);
      check({name, "_net_pixel"}, i, pix_o[i], 0);
      check({name, "_net_coord"}, i, {v_o[i], h_o[i]}, 0);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic tick(input bit st, input bit v, input logic [PW-1:0] d);
    bit b_prev [2], f_prev [2];
    int c;
    start = st;
    if5.src_valid = v;  if40.src_valid = v;
    if5.src_data  = d;  if40.src_data  = d;
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      b_prev[i] = m_busy(i, c);
      f_prev[i] = feeding(i, c);
    end
    @(posedge clock);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      m_pix[i] = (f_prev[i] && v) ? d : '0;
      if (f_prev[i] && !v) begin
        m_ur[i] = 1;
        if (m_err[i] < 65535) m_err[i]++;
      end
      if (m_act[i] && (c == m_f0[i] + lat_of(i) + N)) m_act[i] = 0;
      if (!b_prev[i] && st) begin
        m_act[i] = 1; m_arm[i] = cyc; m_f0[i] = (cyc / N + 1) * N;
        m_ur[i] = 0;  m_err[i] = 0;
      end
    end
    #1;
    check_all();
    for (int i = 0; i < 2; i++) if (done_o[i] === 1'b1) dn_cnt[i]++;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 300 && (m_busy(0, cyc) || m_busy(1, cyc)); n++) tick(0, 1, PW'($urandom));
    check("drain_timeout", 0, n, (n < 300) ? n : -1);
  endtask

  task automatic run_vec(input vec_t t);
    int k;
    bit bad;
    dn_cnt[0] = 0; dn_cnt[1] = 0;
    repeat (t.gap) tick(0, 1, PW'($urandom));
    tick(1, 1, PW'($urandom));
    for (int n = 0; n < 300 && (m_busy(0, cyc) || m_busy(1, cyc)); n++) begin
      k   = cyc - m_f0[0];
      bad = feeding(0, cyc) && ((k == t.bad_a) || (k == t.bad_b));
      tick(0, !bad, PW'($urandom));
    end
    for (int i = 0; i < 2; i++) begin
      check("vec_underrun", i, ur_o[i], t.exp_ur);
      check("vec_err_count", i, err_o[i], ERR_EN ? t.exp_err : 0);
      check("vec_done_count", i, dn_cnt[i], 1);
      check("vec_idle", i, busy_o[i], 0);
    end
  endtask

  initial begin
    int arm_len;
    bit st;
    n_tests = 0; n_fail = 0;
    dn_cnt[0] = 0; dn_cnt[1] = 0;
    start = 0; n_rst = 0;
    if5.src_valid = 0;  if40.src_valid = 0;
    if5.src_data  = '0; if40.src_data  = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 check_zero("reset");
    @(negedge clock) n_rst = 1;

    vecs[0] = '{gap: 0, bad_a: -1, bad_b: -1, exp_ur: 0, exp_err: 0};
    vecs[1] = '{gap: 3, bad_a: 3,  bad_b: 7,  exp_ur: 1, exp_err: 2};
    vecs[2] = '{gap: 9, bad_a: -1, bad_b: -1, exp_ur: 0, exp_err: 0};
    vecs[3] = '{gap: 5, bad_a: 0,  bad_b: 15, exp_ur: 1, exp_err: 2};
    for (int v = 0; v < 4; v++) run_vec(vecs[v]);

    // Start with the scan at (2,1): ARM lasts until the scan wraps.
    for (int n = 0; n < N && (cyc % N) != (2 * WW + 1); n++) tick(0, 1, PW'($urandom));
    tick(1, 1, PW'($urandom));
    arm_len = 0;
    for (int n = 0; n < 40 && rdy_o[0] !== 1'b1; n++) begin
      arm_len++;
      tick(0, 1, PW'($urandom));
    end
    check("arm_hold_len", 0, arm_len, N - 1 - (2 * WW + 1));
    drain();

    // start during FEED and coincident with the LATENCY=5 done: both ignored.
    dn_cnt[0] = 0; dn_cnt[1] = 0;
    tick(1, 1, PW'($urandom));
    for (int n = 0; n < 300 && (m_busy(0, cyc) || m_busy(1, cyc)); n++) begin
      st = (feeding(0, cyc) && (cyc - m_f0[0] == 5)) ||
           (m_act[0] && (cyc == m_f0[0] + 5 + N));
      tick(st, 1, PW'($urandom));
    end
    check("ignored_start_done_count", 0, dn_cnt[0], 1);
    check("ignored_start_done_count", 1, dn_cnt[1], 1);

    // Reset mid-FEED, then a fresh window.
    tick(1, 1, PW'($urandom));
    for (int n = 0; n < 40 && !(feeding(0, cyc) && (cyc - m_f0[0] == 6)); n++)
      tick(0, 0, PW'($urandom));
    #2 n_rst = 0;
    #1 check_zero("midfeed_reset");
    @(negedge clock) n_rst = 1;
    model_clear();
    run_vec('{gap: 2, bad_a: 4, bad_b: -1, exp_ur: 1, exp_err: 1});

    // Random traffic against the model.
    for (int n = 0; n < 400; n++)
      tick($urandom_range(0, 15) == 0, $urandom_range(0, 5) != 0, PW'($urandom));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
